// File: rtl/anubis_tau_stream_transposer_if.sv
// Row-in / word-out stream bundle for anubis_tau_stream_transposer.
// The master modport is the surrounding environment and the slave modport is the transposer.
interface anubis_tau_stream_transposer_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic           s_valid;
  logic           s_ready;
  logic [N*W-1:0] s_data;
  logic           s_mode;
  logic           m_valid;
  logic           m_ready;
  logic [N*W-1:0] m_data;
  logic           m_last;

  modport master (
    output s_valid, s_data, s_mode, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_mode, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/anubis_tau_stream_transposer.sv
// Streaming N x N transposer (Anubis tau successor): rows in, columns out, with
// two ping-pong banks for full-rate back-to-back matrices and a per-matrix pass-through mode.
module anubis_tau_stream_transposer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  anubis_tau_stream_transposer_if.slave  bus
);
  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef logic [W-1:0] elem_t;

  // bank_q[bank][row][column]
  elem_t          bank_q [2][N][N];
  logic [1:0]     full_q, full_d;
  logic [1:0]     mode_q, mode_d;
  logic           wb_q, wb_d;
  logic           rb_q, rb_d;
  logic [CW-1:0]  wr_q, wr_d;
  logic [CW-1:0]  rc_q, rc_d;
  logic           s_ready, m_valid;
  logic           wr_fire, rd_fire;
  logic [N*W-1:0] word;

  assign s_ready     = reset_n && !full_q[wb_q];
  assign m_valid     = full_q[rb_q];
  assign wr_fire     = bus.s_valid && s_ready;
  assign rd_fire     = m_valid && bus.m_ready;

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_last  = m_valid && (rc_q == LAST_IDX);
  assign bus.m_data  = word;

  // A write completion and a read completion never target the same bank,
  // since one requires the bank empty and the other requires it full.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wb_d   = wb_q;
    wr_d   = wr_q;
    rb_d   = rb_q;
    rc_d   = rc_q;
    full_d = full_q;
    mode_d = mode_q;
    if (wr_fire) begin
      if (wr_q == '0) mode_d[wb_q] = bus.s_mode;
      if (wr_q == LAST_IDX) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_d         = '0;
      end else begin
        wr_d = wr_q + CW'(1);
      end
    end
    if (rd_fire) begin
      if (rc_q == LAST_IDX) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rc_d         = '0;
      end else begin
        rc_d = rc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wr_q   <= '0;
      rc_q   <= '0;
      full_q <= '0;
      mode_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wr_q   <= wr_d;
      rc_q   <= rc_d;
      full_q <= full_d;
      mode_q <= mode_d;
    end
  end

  // NOTE: bank storage has no reset; the cleared full flags make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < N; c++) bank_q[wb_q][wr_q][c] <= bus.s_data[W*c +: W];
    end
  end

  // Mode 0 gathers column rc across all rows; mode 1 replays row rc unchanged.
  always_comb begin
    word = '0;
    if (m_valid) begin
      for (int r = 0; r < N; r++) begin
        word[W*r +: W] = mode_q[rb_q] ? bank_q[rb_q][rc_q][r] : bank_q[rb_q][r][rc_q];
      end
    end
  end
endmodule

// File: tb/tb_anubis_tau_stream_transposer.sv
// Self-checking bench: a queue-based tau model checks both instances every cycle,
// while directed sequences pin hand-computed words, latency, capacity and reset behaviour.
module tb_anubis_tau_stream_transposer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  anubis_tau_stream_transposer_if #(.N(4), .W(8)) a_if ();
  anubis_tau_stream_transposer_if #(.N(3), .W(5)) b_if ();

  anubis_tau_stream_transposer #(.N(4), .W(8)) dut_a (.clk(clk), .reset_n(rst_n), .bus(a_if));
  anubis_tau_stream_transposer #(.N(3), .W(5)) dut_b (.clk(clk), .reset_n(rst_n), .bus(b_if));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tau: word k of a matrix, from the rows as written.
  function automatic logic [31:0] tau_word(input logic [31:0] rows[4], input int n, input int w,
                                           input bit mode, input int k);
    logic [31:0] mask;
    logic [31:0] res;
    mask = (32'h1 << w) - 32'h1;
    res  = '0;
    if (mode) return rows[k];
    for (int r = 0; r < n; r++) res |= ((rows[r] >> (w * k)) & mask) << (w * r);
    return res;
  endfunction

  // Matrices still holding a bank: every complete matrix with words left to emit.
  function automatic int pending(input int sz, input int n);
    return (sz + n - 1) / n;
  endfunction

  // ---------------- model for instance A (N=4, W=8) ----------------
  logic [31:0] a_rows[4];
  int          a_nrows = 0;
  bit          a_mode;
  logic [31:0] a_q[$];
  bit          a_lq[$];
  bit          a_rdy;

  always @(posedge clk) begin
    a_rdy = rst_n && (pending(a_q.size(), 4) < 2);
    if (!rst_n) begin
      a_q.delete();
      a_lq.delete();
      a_nrows = 0;
    end else begin
      if (a_if.m_ready && a_q.size() != 0) begin
        void'(a_q.pop_front());
        void'(a_lq.pop_front());
      end
      if (a_if.s_valid && a_rdy) begin
        if (a_nrows == 0) a_mode = a_if.s_mode;
        a_rows[a_nrows] = a_if.s_data;
        a_nrows++;
        if (a_nrows == 4) begin
          for (int k = 0; k < 4; k++) begin
            a_q.push_back(tau_word(a_rows, 4, 8, a_mode, k));
            a_lq.push_back(k == 3);
          end
          a_nrows = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a s_ready", {31'b0, a_if.s_ready}, {31'b0, rst_n && (pending(a_q.size(), 4) < 2)});
      check("a m_valid", {31'b0, a_if.m_valid}, {31'b0, a_q.size() != 0});
      check("a m_last", {31'b0, a_if.m_last}, {31'b0, (a_q.size() != 0) && a_lq[0]});
      check("a m_data", a_if.m_data, (a_q.size() != 0) ? a_q[0] : 32'h0);
    end
  end

  // ---------------- model for instance B (N=3, W=5) ----------------
  logic [31:0] b_rows[4];
  int          b_nrows = 0;
  bit          b_mode;
  logic [31:0] b_q[$];
  bit          b_lq[$];
  bit          b_rdy;

  always @(posedge clk) begin
    b_rdy = rst_n && (pending(b_q.size(), 3) < 2);
    if (!rst_n) begin
      b_q.delete();
      b_lq.delete();
      b_nrows = 0;
    end else begin
      if (b_if.m_ready && b_q.size() != 0) begin
        void'(b_q.pop_front());
        void'(b_lq.pop_front());
      end
      if (b_if.s_valid && b_rdy) begin
        if (b_nrows == 0) b_mode = b_if.s_mode;
        b_rows[b_nrows] = {17'b0, b_if.s_data};
        b_nrows++;
        if (b_nrows == 3) begin
          for (int k = 0; k < 3; k++) begin
            b_q.push_back(tau_word(b_rows, 3, 5, b_mode, k));
            b_lq.push_back(k == 2);
          end
          b_nrows = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("b s_ready", {31'b0, b_if.s_ready}, {31'b0, rst_n && (pending(b_q.size(), 3) < 2)});
      check("b m_valid", {31'b0, b_if.m_valid}, {31'b0, b_q.size() != 0});
      check("b m_last", {31'b0, b_if.m_last}, {31'b0, (b_q.size() != 0) && b_lq[0]});
      check("b m_data", {17'b0, b_if.m_data}, (b_q.size() != 0) ? b_q[0] : 32'h0);
    end
  end

  // ---------------- directed helpers for instance A ----------------
  task automatic a_send(input logic [31:0] rows[4], input bit mode);
    int guard;
    for (int i = 0; i < 4; i++) begin
      a_if.s_valid = 1'b1;
      a_if.s_data  = rows[i];
      // Rows 1..N-1 carry the opposite mode, which must be ignored.
      a_if.s_mode  = (i == 0) ? mode : ~mode;
      @(negedge clk);
      guard = 0;
      while (!a_if.s_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("a_send ready", {31'b0, a_if.s_ready}, 32'h1);
      @(posedge clk); #1;
    end
    a_if.s_valid = 1'b0;
  endtask

  task automatic a_drain(input logic [31:0] exp[4], input string tag);
    a_if.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, " valid"}, {31'b0, a_if.m_valid}, 32'h1);
      check({tag, " data"}, a_if.m_data, exp[k]);
      check({tag, " last"}, {31'b0, a_if.m_last}, {31'b0, k == 3});
      @(posedge clk); #1;
    end
    a_if.m_ready = 1'b0;
  endtask

  logic [31:0] rows_basic[4];
  logic [31:0] exp_t[4];
  logic [31:0] rows_bp[8];
  int          acc_cnt, cyc, words, idle, simul, acc_rows, b_words, b_lasts, b_sent;
  bit          started, acc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rows_basic = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    exp_t      = '{32'h0C080400, 32'h0D090501, 32'h0E0A0602, 32'h0F0B0703};
    for (int i = 0; i < 8; i++) rows_bp[i] = {4{8'(i)}};

    rst_n = 1'b0;
    a_if.s_valid = 1'b0; a_if.s_data = '0; a_if.s_mode = 1'b0; a_if.m_ready = 1'b0;
    b_if.s_valid = 1'b0; b_if.s_data = '0; b_if.s_mode = 1'b0; b_if.m_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset s_ready", {31'b0, a_if.s_ready}, 32'h0);
    check("reset m_valid", {31'b0, a_if.m_valid}, 32'h0);
    check("reset m_last", {31'b0, a_if.m_last}, 32'h0);
    check("reset m_data", a_if.m_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("release s_ready", {31'b0, a_if.s_ready}, 32'h1);
    @(posedge clk); #1;

    // Basic transpose and first-word latency
    for (int i = 0; i < 4; i++) begin
      a_if.s_valid = 1'b1; a_if.s_data = rows_basic[i]; a_if.s_mode = 1'b0;
      @(negedge clk);
      check("basic s_ready", {31'b0, a_if.s_ready}, 32'h1);
      check("basic early m_valid", {31'b0, a_if.m_valid}, 32'h0);
      @(posedge clk); #1;
    end
    a_if.s_valid = 1'b0;
    @(negedge clk);
    check("basic latency m_valid", {31'b0, a_if.m_valid}, 32'h1);
    check("basic word0", a_if.m_data, 32'h0C080400);
    @(posedge clk); #1;
    a_drain(exp_t, "basic");
    @(negedge clk);
    check("basic empty", {31'b0, a_if.m_valid}, 32'h0);
    @(posedge clk); #1;

    // Pass-through then transpose: mode is per matrix
    a_send(rows_basic, 1'b1);
    a_send(rows_basic, 1'b0);
    a_drain(rows_basic, "pass");
    a_drain(exp_t, "after pass");

    // Back-pressure: 12 rows offered, 8 fit
    acc_cnt = 0;
    a_if.m_ready = 1'b0;
    a_if.s_valid = 1'b1; a_if.s_mode = 1'b0; a_if.s_data = rows_bp[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = a_if.s_valid && a_if.s_ready;
      if (a_if.m_valid) check("bp stall data", a_if.m_data, 32'h03020100);
      @(posedge clk); #1;
      if (acc) begin
        acc_cnt++;
        if (acc_cnt < 8) a_if.s_data = rows_bp[acc_cnt];
      end
    end
    a_if.s_valid = 1'b0;
    check("bp accepted", acc_cnt, 8);
    @(negedge clk);
    check("bp s_ready held low", {31'b0, a_if.s_ready}, 32'h0);
    @(posedge clk); #1;
    a_if.m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bp drain data", a_if.m_data, (k < 4) ? 32'h03020100 : 32'h07060504);
      check("bp drain s_ready", {31'b0, a_if.s_ready}, {31'b0, k >= 4});
      @(posedge clk); #1;
    end
    a_if.m_ready = 1'b0;
    @(negedge clk);
    check("bp drained", {31'b0, a_if.m_valid}, 32'h0);
    @(posedge clk); #1;

    // Streaming: 16 matrices, s_valid and m_ready held high
    a_if.m_ready = 1'b1; a_if.s_valid = 1'b1; a_if.s_mode = 1'b0; a_if.s_data = $urandom;
    cyc = 0; words = 0; idle = 0; simul = 0; acc_rows = 0; started = 1'b0;
    while (words < 64 && cyc < 400) begin
      @(negedge clk);
      acc = a_if.s_valid && a_if.s_ready;
      if (a_if.m_valid) started = 1'b1;
      else if (started) idle++;
      if (a_if.m_valid && a_if.m_ready) begin
        words++;
        if (acc && (acc_rows % 4 == 3) && a_if.m_last) simul++;
      end
      if (acc) acc_rows++;
      @(posedge clk); #1;
      if (acc) begin
        if (acc_rows == 64) a_if.s_valid = 1'b0;
        else a_if.s_data = $urandom;
      end
      cyc++;
    end
    a_if.s_valid = 1'b0; a_if.m_ready = 1'b0;
    check("stream words", words, 64);
    check("stream idle cycles", idle, 0);
    check("stream cycles", cyc, 68);
    check("stream fill+free same edge", {31'b0, simul != 0}, 32'h1);

    // Mid-operation reset
    a_send(rows_basic, 1'b0);
    a_if.s_valid = 1'b1; a_if.s_data = 32'hDEADBEEF; a_if.m_ready = 1'b1;
    @(posedge clk); #1;
    a_if.s_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    a_if.s_valid = 1'b0; a_if.m_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset m_valid", {31'b0, a_if.m_valid}, 32'h0);
    check("post-reset s_ready", {31'b0, a_if.s_ready}, 32'h1);
    @(posedge clk); #1;
    a_send(rows_basic, 1'b0);
    a_drain(exp_t, "post-reset");
    @(negedge clk);
    check("post-reset no stale", {31'b0, a_if.m_valid}, 32'h0);
    @(posedge clk); #1;

    // Random handshakes on N=3, W=5: 1000 matrices
    b_sent = 0; b_words = 0; b_lasts = 0; cyc = 0;
    b_if.s_data = 15'($urandom); b_if.s_mode = 1'($urandom_range(0, 1));
    b_if.s_valid = ($urandom_range(0, 3) != 0);
    b_if.m_ready = ($urandom_range(0, 2) != 0);
    while (b_words < 3000 && cyc < 20000) begin
      @(negedge clk);
      acc = b_if.s_valid && b_if.s_ready;
      if (b_if.m_valid && b_if.m_ready) begin
        check("b last period", {31'b0, b_if.m_last}, {31'b0, (b_words % 3) == 2});
        b_words++;
        if (b_if.m_last) b_lasts++;
      end
      @(posedge clk); #1;
      if (acc) begin
        b_sent++;
        b_if.s_data = 15'($urandom);
        b_if.s_mode = 1'($urandom_range(0, 1));
      end
      b_if.s_valid = (b_sent < 3000) && ($urandom_range(0, 3) != 0);
      b_if.m_ready = ($urandom_range(0, 2) != 0);
      cyc++;
    end
    b_if.s_valid = 1'b0; b_if.m_ready = 1'b0;
    check("b rows sent", b_sent, 3000);
    check("b words", b_words, 3000);
    check("b last count", b_lasts, 1000);
    @(negedge clk);
    check("b drained", {31'b0, b_if.m_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
